cpu_multicycle: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 8-bit CPU core. It generalises data width and register count and adds a ready/request instruction-fetch handshake, so instruction memory may insert wait states. It also adds arithmetic shift, rotate, halt and illegal-opcode handling. It sits between the testbench or SoC instruction memory and an internal register file, and keeps the existing 32-bit instruction encoding.

---
 rtl/cpu_multicycle.sv | 166 ++++++++++++++++
 tb/tb_cpu_multicycle.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// Parametrised multi-cycle CPU core with a ready/request instruction-fetch handshake.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK; HALT parks the core until reset.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IMEM_READY,
  output logic [31:0] PC,
  output logic        IMEM_REQ,
  output logic        RETIRE,
  output logic        ILLEGAL,
  output logic        HALTED
);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_SLL   = 8'h0A;
  localparam logic [7:0] OP_SRL   = 8'h0B;
  localparam logic [7:0] OP_SRA   = 8'h0C;
  localparam logic [7:0] OP_ROR   = 8'h0D;
  localparam logic [7:0] OP_BNE   = 8'h0F;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t            state, state_next;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, result;
  logic              zero;
  logic [DATA_W-1:0] regs [NREG];

  logic [7:0]        opcode, imm, rot_amt;
  logic [RW-1:0]     rd, rs1, rs2;
  logic [DATA_W-1:0] imm_ext, alu_out;
  logic [31:0]       pc_plus4, target;
  logic              writes_rd, is_legal, is_halt, taken;

  assign opcode = ir[31:24];
  assign rd     = RW'(ir[23:16]);
  assign rs1    = RW'(ir[15:8]);
  assign rs2    = RW'(ir[7:0]);
  assign imm    = ir[7:0];

  assign imm_ext  = DATA_W'(signed'(imm));
  assign rot_amt  = imm % 8'(DATA_W);
  assign pc_plus4 = PC + 32'd4;
  assign target   = pc_plus4 + (32'(signed'(ir[23:16])) << 2);

  assign is_halt = (opcode == OP_HALT);
  assign taken   = (opcode == OP_J) ||
                   ((opcode == OP_BEQ) && zero) ||
                   ((opcode == OP_BNE) && !zero);

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    writes_rd = 1'b0;
    is_legal  = 1'b1;
    case (opcode)
      OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: writes_rd = 1'b1;
      OP_J, OP_BEQ, OP_BNE, OP_HALT:  ;
      default:                        is_legal = 1'b0;
    endcase
  end

  // Shift amounts of DATA_W or more saturate explicitly rather than relying on operator corner cases.
  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_LOADI: alu_out = imm_ext;
      OP_MOV:   alu_out = b;
      OP_ADD:   alu_out = a + b;
      OP_SUB:   alu_out = a - b;
      OP_AND:   alu_out = a & b;
      OP_OR:    alu_out = a | b;
      OP_SLL:   alu_out = (imm >= 8'(DATA_W)) ? '0 : (a << imm);
      OP_SRL:   alu_out = (imm >= 8'(DATA_W)) ? '0 : (a >> imm);
      OP_SRA:   alu_out = (imm >= 8'(DATA_W)) ? {DATA_W{a[DATA_W-1]}}
                                              : DATA_W'($signed(a) >>> imm);
      OP_ROR:   alu_out = (a >> rot_amt) | (a << (8'(DATA_W) - rot_amt));
      default:  alu_out = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    IMEM_REQ   = 1'b0;
    RETIRE     = 1'b0;
    ILLEGAL    = 1'b0;
    HALTED     = 1'b0;
    case (state)
      S_IDLE:    state_next = S_FETCH;
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_READY) state_next = S_DECODE;
      end
      S_DECODE:  state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_WRITEBACK;
      S_WRITEBACK: begin
        RETIRE     = 1'b1;
        ILLEGAL    = !is_legal;
        state_next = is_halt ? S_HALT : S_FETCH;
      end
      S_HALT:    HALTED = 1'b1;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      result <= '0;
      zero   <= 1'b0;
      PC     <= '0;
    end else begin
      case (state)
        S_FETCH:     if (IMEM_READY) ir <= INSTRUCTION;
        S_DECODE: begin
          a <= regs[rs1];
          b <= regs[rs2];
        end
        S_EXECUTE: begin
          result <= alu_out;
          zero   <= (a == b);
        end
        S_WRITEBACK: if (!is_halt) PC <= taken ? target : pc_plus4;
        default:     ;
      endcase
    end
  end

  // NOTE: the register file is architecturally reset to zero, so the array sits inside the reset branch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (state == S_WRITEBACK && writes_rd) begin
      regs[rd] <= result;
    end
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: an 8-bit/8-register core and a 16-bit/16-register core
// share one clock; each has its own program ROM indexed by PC[7:2].
module tb_cpu_multicycle;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst8 = 1'b1, ready8 = 1'b1;
  logic [31:0] pc8, instr8;
  logic        req8, ret8, ill8, hlt8;
  logic [31:0] prog8 [64];
  assign instr8 = prog8[pc8[7:2]];

  logic        rst16 = 1'b1, ready16 = 1'b1;
  logic [31:0] pc16, instr16;
  logic        req16, ret16, ill16, hlt16;
  logic [31:0] prog16 [64];
  assign instr16 = prog16[pc16[7:2]];

  cpu_multicycle #(.DATA_W(8), .NREG(8)) dut8 (
    .CLK(clk), .RESET(rst8), .INSTRUCTION(instr8), .IMEM_READY(ready8),
    .PC(pc8), .IMEM_REQ(req8), .RETIRE(ret8), .ILLEGAL(ill8), .HALTED(hlt8)
  );

  cpu_multicycle #(.DATA_W(16), .NREG(16)) dut16 (
    .CLK(clk), .RESET(rst16), .INSTRUCTION(instr16), .IMEM_READY(ready16),
    .PC(pc16), .IMEM_REQ(req16), .RETIRE(ret16), .ILLEGAL(ill16), .HALTED(hlt16)
  );

  // All stimulus changes and samples happen on falling edges, half a cycle from the active edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Puts dut8 in reset, clears its ROM; caller loads the program, then calls release8.
  task automatic hold8();
    rst8 = 1'b0;
    for (int i = 0; i < 64; i++) prog8[i] = 32'h0;
    step(1);
  endtask

  // Releases reset and advances through IDLE -> FETCH.
  task automatic release8();
    rst8 = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    #1;
    rst8  = 1'b0;
    rst16 = 1'b0;
    #1;
    n_tests++;
    if ({pc8, req8, ret8, ill8, hlt8} !== {32'h0, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: pc=%h req/ret/ill/hlt=%b%b%b%b, want pc=0 all 0",
               pc8, req8, ret8, ill8, hlt8);
    end
    step(2);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (dut8.regs[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg r%0d: got %h want 00", i, dut8.regs[i]);
      end
    end
    n_tests++;
    if ({pc16, req16, hlt16} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_wide: pc=%h req=%b hlt=%b want 0", pc16, req16, hlt16);
    end
  endtask

  task automatic test_load_shift();
    int          retire_at [$];
    logic        ill_seen = 1'b0;
    int          exp_at [4]  = '{3, 7, 11, 15};
    int          ridx [4]    = '{4, 5, 6, 7};
    logic [7:0]  rval [4]    = '{8'h0A, 8'h0A, 8'h28, 8'h02};
    hold8();
    prog8[0] = 32'h00_04_00_0A;  // LOADI r4,0x0A
    prog8[1] = 32'h00_05_00_0A;  // LOADI r5,0x0A
    prog8[2] = 32'h0A_06_04_02;  // SLL r6,r4,2
    prog8[3] = 32'h0B_07_05_02;  // SRL r7,r5,2
    prog8[4] = 32'h0F_FE_06_07;  // BNE r6,r7,-2
    ready8 = 1'b1;
    release8();
    for (int c = 1; c <= 16; c++) begin
      step(1);
      if (ret8) retire_at.push_back(c);
      if (ill8) ill_seen = 1'b1;
    end
    n_tests++;
    if (retire_at.size() != 4) begin
      n_fail++;
      $display("FAIL retire_count: got %0d pulses want 4", retire_at.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= retire_at.size() || retire_at[i] != exp_at[i]) begin
        n_fail++;
        $display("FAIL retire_cycle%0d: got %0d want %0d", i,
                 (i < retire_at.size()) ? retire_at[i] : -1, exp_at[i]);
      end
    end
    n_tests++;
    if (ill_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL legal_no_illegal: ILLEGAL seen=%b want 0", ill_seen);
    end
    n_tests++;
    if (pc8 !== 32'd16) begin
      n_fail++;
      $display("FAIL pc_after_16: got %0d want 16", pc8);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (dut8.regs[ridx[i]] !== rval[i]) begin
        n_fail++;
        $display("FAIL shift_reg r%0d: got %h want %h", ridx[i], dut8.regs[ridx[i]], rval[i]);
      end
    end
    step(4);
    n_tests++;
    if (pc8 !== 32'd12) begin
      n_fail++;
      $display("FAIL bne_taken_back: got %0d want 12", pc8);
    end
  endtask

  task automatic test_branches();
    logic [31:0] exp_pc [14] = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd28, 32'd32, 32'd36,
                                 32'd40, 32'd44, 32'd48, 32'd52, 32'hFFFF_FFFC, 32'd0, 32'd4};
    logic [7:0]  rval [8] = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h0A, 8'hFB, 8'h0A, 8'hFB};
    hold8();
    prog8[0]  = 32'h00_01_00_05;  // LOADI r1,5
    prog8[1]  = 32'h00_02_00_05;  // LOADI r2,5
    prog8[2]  = 32'h06_00_00_00;  // J +0
    prog8[3]  = 32'h01_03_00_01;  // MOV r3,r1
    prog8[4]  = 32'h07_02_01_02;  // BEQ r1,r2,+2 (taken)
    prog8[5]  = 32'h00_00_00_EE;  // skipped
    prog8[6]  = 32'h00_00_00_EE;  // skipped
    prog8[7]  = 32'h0F_10_01_03;  // BNE r1,r3 (not taken)
    prog8[8]  = 32'h02_04_01_02;  // ADD r4,r1,r2
    prog8[9]  = 32'h03_05_01_04;  // SUB r5,r1,r4 (wraps)
    prog8[10] = 32'h04_06_05_04;  // AND r6,r5,r4
    prog8[11] = 32'h05_07_05_04;  // OR r7,r5,r4
    prog8[12] = 32'h07_04_04_05;  // BEQ r4,r5 (not taken)
    prog8[13] = 32'h06_F1_00_00;  // J -15 -> 0xFFFFFFFC
    prog8[63] = 32'h06_00_00_00;  // J +0 -> wraps to 0
    ready8 = 1'b1;
    release8();
    for (int i = 0; i < 14; i++) begin
      step(4);
      n_tests++;
      if (pc8 !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL branch_pc%0d: got %h want %h", i, pc8, exp_pc[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (dut8.regs[i] !== rval[i]) begin
        n_fail++;
        $display("FAIL branch_reg r%0d: got %h want %h", i, dut8.regs[i], rval[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    hold8();
    prog8[0] = 32'h00_00_00_7F;  // LOADI r0,0x7F
    ready8 = 1'b0;
    release8();
    for (int c = 1; c <= 3; c++) begin
      step(1);
      n_tests++;
      if ({req8, pc8} !== {1'b1, 32'h0}) begin
        n_fail++;
        $display("FAIL wait_hold%0d: req=%b pc=%h want req=1 pc=0", c, req8, pc8);
      end
    end
    ready8 = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      step(1);
      n_tests++;
      if (ret8 !== (c == 6)) begin
        n_fail++;
        $display("FAIL wait_retire_c%0d: got %b want %b", c, ret8, (c == 6));
      end
      if (c == 4) begin
        n_tests++;
        if (req8 !== 1'b0) begin
          n_fail++;
          $display("FAIL req_fall: got %b want 0", req8);
        end
      end
    end
    n_tests++;
    if ({pc8, dut8.regs[0]} !== {32'd4, 8'h7F}) begin
      n_fail++;
      $display("FAIL wait_result: pc=%h r0=%h want pc=4 r0=7F", pc8, dut8.regs[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic ret_seen = 1'b0;
    hold8();
    prog8[0] = 32'h00_02_00_03;  // LOADI r2,3
    prog8[1] = 32'h00_03_00_04;  // LOADI r3,4
    prog8[2] = 32'h02_01_02_03;  // ADD r1,r2,r3
    ready8 = 1'b1;
    release8();
    step(10);
    n_tests++;
    if ({pc8, dut8.regs[2], dut8.regs[3]} !== {32'd8, 8'h03, 8'h04}) begin
      n_fail++;
      $display("FAIL mid_setup: pc=%h r2=%h r3=%h want 8 03 04", pc8, dut8.regs[2], dut8.regs[3]);
    end
    #2;
    rst8 = 1'b0;
    #1;
    n_tests++;
    if ({pc8, req8, ret8} !== {32'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_reset_async: pc=%h req=%b ret=%b want 0 0 0", pc8, req8, ret8);
    end
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (ret8 || req8) ret_seen = 1'b1;
    end
    n_tests++;
    if ({ret_seen, dut8.regs[1]} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_no_retire: activity=%b r1=%h want 0 00", ret_seen, dut8.regs[1]);
    end
    release8();
    n_tests++;
    if ({req8, pc8} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_restart: req=%b pc=%h want 1 0", req8, pc8);
    end
    step(4);
    n_tests++;
    if ({pc8, dut8.regs[2]} !== {32'd4, 8'h03}) begin
      n_fail++;
      $display("FAIL mid_refetch: pc=%h r2=%h want 4 03", pc8, dut8.regs[2]);
    end
  endtask

  task automatic test_illegal_halt();
    hold8();
    prog8[0] = 32'h00_01_00_33;  // LOADI r1,0x33
    prog8[1] = 32'h09_01_01_01;  // undefined opcode
    prog8[2] = 32'hFF_00_00_00;  // HALT
    prog8[3] = 32'h00_02_00_55;  // must never run
    ready8 = 1'b1;
    release8();
    step(3);
    n_tests++;
    if ({ret8, ill8} !== 2'b10) begin
      n_fail++;
      $display("FAIL loadi_wb: ret/ill=%b%b want 10", ret8, ill8);
    end
    step(4);
    n_tests++;
    if ({ret8, ill8} !== 2'b11) begin
      n_fail++;
      $display("FAIL illegal_wb: ret/ill=%b%b want 11", ret8, ill8);
    end
    step(1);
    n_tests++;
    if ({pc8, ill8, dut8.regs[1]} !== {32'd8, 1'b0, 8'h33}) begin
      n_fail++;
      $display("FAIL illegal_after: pc=%h ill=%b r1=%h want 8 0 33", pc8, ill8, dut8.regs[1]);
    end
    step(3);
    n_tests++;
    if ({ret8, ill8, hlt8} !== 3'b100) begin
      n_fail++;
      $display("FAIL halt_wb: ret/ill/hlt=%b%b%b want 100", ret8, ill8, hlt8);
    end
    for (int c = 0; c < 21; c++) begin
      step(1);
      n_tests++;
      if ({hlt8, req8, ret8, pc8} !== {3'b100, 32'd8}) begin
        n_fail++;
        $display("FAIL halted_c%0d: hlt/req/ret=%b%b%b pc=%h want 100 pc=8",
                 c, hlt8, req8, ret8, pc8);
      end
    end
    n_tests++;
    if (dut8.regs[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL halt_no_exec: r2=%h want 00", dut8.regs[2]);
    end
    rst8 = 1'b0;
    #1;
    n_tests++;
    if (hlt8 !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_cleared: got %b want 0", hlt8);
    end
  endtask

  task automatic test_wide();
    int          ridx [11] = '{15, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    logic [15:0] rval [11] = '{16'hFF80, 16'hFFF8, 16'h0FF8, 16'h0000, 16'h0000, 16'hFFFF,
                               16'h0FF8, 16'h0001, 16'hFFFF, 16'h0001, 16'h007F};
    for (int i = 0; i < 64; i++) prog16[i] = 32'h0;
    prog16[0]  = 32'h00_0F_00_80;  // LOADI r15,0x80
    prog16[1]  = 32'h0C_01_0F_04;  // SRA r1,r15,4
    prog16[2]  = 32'h0D_02_0F_04;  // ROR r2,r15,4
    prog16[3]  = 32'h0A_03_0F_14;  // SLL r3,r15,20
    prog16[4]  = 32'h0B_04_0F_10;  // SRL r4,r15,16
    prog16[5]  = 32'h0C_05_0F_10;  // SRA r5,r15,16
    prog16[6]  = 32'h0D_06_0F_14;  // ROR r6,r15,20
    prog16[7]  = 32'h00_F7_00_01;  // LOADI r7 (upper dest bits ignored)
    prog16[8]  = 32'h0C_08_0F_0F;  // SRA r8,r15,15
    prog16[9]  = 32'h0B_09_0F_0F;  // SRL r9,r15,15
    prog16[10] = 32'h00_0A_00_7F;  // LOADI r10,0x7F
    ready16 = 1'b1;
    step(1);
    rst16 = 1'b1;
    step(1);
    step(44);
    n_tests++;
    if (pc16 !== 32'd44) begin
      n_fail++;
      $display("FAIL wide_pc: got %0d want 44", pc16);
    end
    for (int i = 0; i < 11; i++) begin
      n_tests++;
      if (dut16.regs[ridx[i]] !== rval[i]) begin
        n_fail++;
        $display("FAIL wide_reg r%0d: got %h want %h", ridx[i], dut16.regs[ridx[i]], rval[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_branches();
    test_wait_states();
    test_reset_mid();
    test_illegal_halt();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
